// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Define BCD_SAT_EN to force bcd_out to all nines whenever over is set.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  sign_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign_out,
  output logic                  over
);

  localparam int BCD_W = 4 * (DIGITS + 1);
  localparam int SW    = BCD_W + BIN_W;
  localparam int CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_FIN
  } state_t;

  state_t              r_state, w_state;
  logic [SW-1:0]       r_shift, w_shift, w_adj;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic                r_sign, w_sign;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic [4*DIGITS-1:0] r_bcd, w_bcd, w_low;
  logic                r_sign_out, w_sign_out;
  logic                r_over, w_over, w_over_calc;
  logic [3:0]          w_top;

  // Add-3 correction on every BCD nibble before the shift
  always_comb begin
    w_adj = r_shift;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (r_shift[BIN_W + 4*i +: 4] >= 4'd5)
        w_adj[BIN_W + 4*i +: 4] = r_shift[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  assign w_top       = r_shift[SW-1 -: 4];
  assign w_low       = r_shift[BIN_W +: 4*DIGITS];
  assign w_over_calc = (w_top != 4'd0);

  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_cnt      = r_cnt;
    w_sign     = r_sign;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_bcd      = r_bcd;
    w_sign_out = r_sign_out;
    w_over     = r_over;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shift = SW'(bin_in);
          w_sign  = sign_in;
          w_cnt   = '0;
          w_busy  = 1'b1;
          w_state = S_CONV;
        end
      end
      S_CONV: begin
        w_shift = {w_adj[SW-2:0], 1'b0};
        w_cnt   = r_cnt + 1'b1;
        if (r_cnt == CW'(BIN_W - 1))
          w_state = S_FIN;
      end
      S_FIN: begin
        w_over     = w_over_calc;
`ifdef BCD_SAT_EN
        w_bcd      = w_over_calc ? {DIGITS{4'd9}} : w_low;
`else
        w_bcd      = w_low;
`endif
        w_sign_out = r_sign;
        w_done     = 1'b1;
        w_busy     = 1'b0;
        w_state    = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_sign     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bcd      <= '0;
      r_sign_out <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_cnt      <= w_cnt;
      r_sign     <= w_sign;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_bcd      <= w_bcd;
      r_sign_out <= w_sign_out;
      r_over     <= w_over;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign bcd_out  = r_bcd;
  assign sign_out = r_sign_out;
  assign over     = r_over;

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble). Performs the inverse of the combinational BCD-to-binary stage.
- Takes a 14-bit unsigned ALU magnitude plus a sign bit, and returns 4 BCD digits, the sign and an over-range flag. Uses a start/busy/done handshake.
- Sits between the ALU core and the display/result storage. Replaces the combinational result conversion so that timing at 12 MHz stays off the critical path.

Parameters:
- BIN_W, 14, width of the binary magnitude input. Must satisfy 2^BIN_W-1 < 10^(DIGITS+1).
- DIGITS, 4, number of BCD digits presented at the output. Internally DIGITS+1 digits are computed.

Ports:
- clk  input  1  system clock (12 MHz HFOSC)
- rst_n  input  1  synchronous active-low reset
- start  input  1  request conversion; sampled only when idle
- bin_in  input  BIN_W  unsigned magnitude; captured on the accepted start
- sign_in  input  1  sign of the result (1 = negative); captured with bin_in
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse when the outputs update
- bcd_out  output  4*DIGITS  {d3,d2,d1,d0}, 4 bits per digit, d0 least significant
- sign_out  output  1  registered copy of the captured sign_in
- over  output  1  captured bin_in > 10^DIGITS-1 (9999 by default)

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0 every register clears. Clears: busy=0, done=0, bcd_out=0, sign_out=0, over=0, state=IDLE, iteration count=0. A conversion in progress is aborted and no done pulse is issued for it.
- FSM states: IDLE, CONV, FIN.
- IDLE:
  - start=1 at edge k loads the shift register with {(DIGITS+1)*4 zeros, bin_in}, latches sign_in, clears the count and moves to CONV.
  - busy=1 from edge k onward.
- CONV, one iteration per edge:
  - Every BCD nibble >=5 gets +3.
  - The whole shift register then shifts left by 1.
  - The count increments. The iteration with count=BIN_W-1 moves to FIN.
  - CONV therefore occupies edges k+1..k+BIN_W.
- FIN, at edge k+BIN_W+1:
  - Register the outputs.
  - over = (top internal digit != 0).
  - sign_out = latched sign.
  - done=1 for exactly that cycle, busy=0, return to IDLE.
  - Total latency is BIN_W+1 edges (15) from the accepted start to done visible.
- A start while busy=1 is ignored and is not queued. bin_in/sign_in may change freely while busy.
- A start in the done cycle (state IDLE) is accepted, giving back-to-back conversions every BIN_W+2 cycles.
- bcd_out, sign_out and over hold their last values between done pulses and while busy.
- Every output nibble is always in the range 0..9.
- bin_in=0 goes through the full latency and produces 0000, over=0.
- Sign is passed through unchanged, including for a 0 magnitude. There is no negative-zero suppression.

Optional Feature:
- Macro BCD_SAT_EN.
- Defined: when over=1, bcd_out is forced to all nines (9999). over is still asserted.
- Undefined: bcd_out carries the low DIGITS digits of the true value, e.g. 12345 -> 2345, with over=1.
- In both builds over=0 results are identical, and latency and handshake are identical.

Test Plan:
- Reset then start with bin_in=1234, sign_in=0 at edge k -> busy high edges k..k+14; done single pulse after edge k+15; bcd_out=16'h1234, over=0, sign_out=0.
- bin_in=0 and bin_in=9999 with sign_in=1 -> 16'h0000 / 16'h9999, over=0, sign_out=1, latency 15 edges each.
- bin_in=16383:
  - BCD_SAT_EN defined -> bcd_out=16'h9999, over=1.
  - BCD_SAT_EN undefined -> bcd_out=16'h6383, over=1.
- start with 4321, then start pulses with 1111 on edges k+3..k+10 -> exactly one done; result 16'h4321. Then start in the done cycle with 0042 -> second done 16 cycles after the first, with 16'h0042.
- rst_n=0 for one edge at k+7 of a conversion of 5678 -> all outputs 0, busy=0, no done. A fresh start of 5678 then completes normally with 16'h5678.
- Sweep of 0..10000 with a scoreboard -> every nibble <=9 and decimal(bcd_out)=bin_in for bin_in<=9999. 10000 -> over=1, bcd_out 16'h9999 (SAT build) or 16'h0000 (non-SAT build).
